addsub_stage: RTL and testbench



---
 rtl/addsub_pkg.sv | 18 +
 rtl/addsub32.sv | 37 +++
 rtl/addsub_stage.sv | 111 +++++++++++
 tb/tb_addsub_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types for the add/sub issue stage: opcode and output-register state encodings.
package addsub_pkg;

  localparam int ADDSUB_W = 32;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_ACC = 2'd2,
    OP_CLR = 2'd3
  } op_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/addsub32.sv
// 32-bit ripple-carry adder/subtractor: ans = A + (B ^ SUB) + SUB, with carry out
// and signed overflow taken from the carries into and out of the MSB.
module addsub32 (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        SUB,
  output logic [31:0] ans,
  output logic        cout,
  output logic        V
);

  logic [31:0] b_eff;
  logic [31:0] sum_bits;
  logic        carry_msb_in;
  logic        carry_out;

  assign b_eff = B ^ {32{SUB}};

  // The carry lives in a block-local variable so the chain is one ordered ripple.
  always_comb begin
    logic carry;
    carry        = SUB;
    carry_msb_in = 1'b0;
    sum_bits     = '0;
    for (int i = 0; i < 32; i++) begin
      if (i == 31) carry_msb_in = carry;
      sum_bits[i] = A[i] ^ b_eff[i] ^ carry;
      carry       = (A[i] & b_eff[i]) | (carry & (A[i] ^ b_eff[i]));
    end
    carry_out = carry;
  end

  assign ans  = sum_bits;
  assign cout = carry_out;
  assign V    = carry_msb_in ^ carry_out;

endmodule

// File: rtl/addsub_stage.sv
// Registered valid/ready stage around addsub32 with a running accumulator.
// Define ADDSUB_STICKY_V_EN to make out_v accumulate overflows until CLR or reset.
module addsub_stage
  import addsub_pkg::*;
#(
  parameter int WIDTH = ADDSUB_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_ans,
  output logic             out_cout,
  output logic             out_v,
  output logic             out_z,
  output logic             out_n,
  output logic [WIDTH-1:0] acc
);

  if (WIDTH != ADDSUB_W) begin : g_bad_width
    $error("addsub_stage: WIDTH must be 32");
  end

  state_t           state_reg;
  logic [WIDTH-1:0] ans_reg;
  logic             cout_reg;
  logic             v_reg;
  logic [WIDTH-1:0] acc_reg;

  op_t              op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sub;
  logic [WIDTH-1:0] sum;
  logic             sum_cout;
  logic             sum_v;
  logic             v_next;
  logic             in_xfer;
  logic             out_xfer;

  assign op        = op_t'(in_op);
  assign out_valid = (state_reg == ST_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    op_a   = in_a;
    op_b   = in_b;
    op_sub = 1'b0;
    unique case (op)
      OP_ADD: begin op_a = in_a;    op_b = in_b; op_sub = 1'b0; end
      OP_SUB: begin op_a = in_a;    op_b = in_b; op_sub = 1'b1; end
      OP_ACC: begin op_a = acc_reg; op_b = in_a; op_sub = 1'b0; end
      OP_CLR: begin op_a = '0;      op_b = '0;   op_sub = 1'b0; end
      default: ;
    endcase
  end

  addsub32 u_adder (
    .A    (op_a),
    .B    (op_b),
    .SUB  (op_sub),
    .ans  (sum),
    .cout (sum_cout),
    .V    (sum_v)
  );

`ifdef ADDSUB_STICKY_V_EN
  // v_reg doubles as the sticky overflow flag; CLR is the only non-reset clear.
  assign v_next = (op == OP_CLR) ? 1'b0 : (v_reg | sum_v);
`else
  assign v_next = sum_v;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_EMPTY;
      ans_reg   <= '0;
      cout_reg  <= 1'b0;
      v_reg     <= 1'b0;
      acc_reg   <= '0;
    end else begin
      if (in_xfer) begin
        ans_reg  <= sum;
        cout_reg <= sum_cout;
        v_reg    <= v_next;
        if (op == OP_ACC)      acc_reg <= sum;
        else if (op == OP_CLR) acc_reg <= '0;
      end
      unique case (state_reg)
        ST_EMPTY: if (in_xfer)              state_reg <= ST_FULL;
        ST_FULL:  if (out_xfer && !in_xfer) state_reg <= ST_EMPTY;
        default:                            state_reg <= ST_EMPTY;
      endcase
    end
  end

  assign out_ans  = ans_reg;
  assign out_cout = cout_reg;
  assign out_v    = v_reg;
  assign out_z    = (ans_reg == '0);
  assign out_n    = ans_reg[WIDTH-1];
  assign acc      = acc_reg;

endmodule

// File: tb/tb_addsub_stage.sv
// Scoreboard bench for addsub_stage: directed scenarios plus randomized traffic and backpressure.
module tb_addsub_stage;

  typedef struct packed {
    logic [31:0] ans;
    logic        cout;
    logic        v;
    logic [31:0] acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'd0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_ans;
  logic        out_cout;
  logic        out_v;
  logic        out_z;
  logic        out_n;
  logic [31:0] acc;

  int   total = 0;
  int   bad = 0;
  int   ready_mode = 0;
  exp_t sb_q[$];
  exp_t exp_last;
  logic [31:0] acc_m = '0;
  logic        sticky_m = 1'b0;

  addsub_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ans(out_ans), .out_cout(out_cout), .out_v(out_v), .out_z(out_z), .out_n(out_n),
    .acc(acc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference behaviour from plain 33-bit arithmetic and sign rules.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [32:0] s;
    logic        ov;
    s  = '0;
    ov = 1'b0;
    case (op)
      2'd0: begin s = {1'b0, a} + {1'b0, b};          ov = (a[31] == b[31]) && (s[31] != a[31]); end
      2'd1: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; ov = (a[31] != b[31]) && (s[31] != a[31]); end
      2'd2: begin s = {1'b0, acc_m} + {1'b0, a};      ov = (acc_m[31] == a[31]) && (s[31] != acc_m[31]);
                  acc_m = s[31:0]; end
      default: begin s = '0; ov = 1'b0; acc_m = '0; end
    endcase
`ifdef ADDSUB_STICKY_V_EN
    sticky_m = (op == 2'd3) ? 1'b0 : (sticky_m | ov);
    e.v = sticky_m;
`else
    e.v = ov;
`endif
    e.ans  = s[31:0];
    e.cout = s[32];
    e.acc  = acc_m;
    return e;
  endfunction

  // Entered and left at posedge+1; holds the transaction until accepted.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    #1;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #2;
      guard++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout op=%0d actual=stalled required=accepted", op);
      in_valid = 1'b0;
      return;
    end
    exp_last = model(op, a, b);
    sb_q.push_back(exp_last);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [31:0] ans, input logic c,
                            input logic v, input logic z, input logic n);
    chk(name, {28'd0, out_valid, out_ans, out_cout, out_v, out_z, out_n},
              {28'd0, 1'b1, ans, c, v, z, n});
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected actual=ans:%h required=no_output", out_ans);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if ({out_ans, out_cout, out_v, out_z, out_n, acc} !==
            {e.ans, e.cout, e.v, (e.ans == 32'd0), e.ans[31], e.acc}) begin
          bad++;
          $display("FAIL sb_result actual=ans:%h c:%b v:%b z:%b n:%b acc:%h required=ans:%h c:%b v:%b z:%b n:%b acc:%h",
                   out_ans, out_cout, out_v, out_z, out_n, acc,
                   e.ans, e.cout, e.v, (e.ans == 32'd0), e.ans[31], e.acc);
        end else begin
          $display("txn ans=%h c=%b v=%b z=%b n=%b acc=%h", out_ans, out_cout, out_v, out_z, out_n, acc);
        end
      end
    end
  end

  initial begin
    logic [31:0] picks [5];
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_state", {out_valid, in_ready, out_ans, out_cout, out_v, out_z, out_n, acc},
                       {1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0});
    @(posedge clk); #1;
    rst = 1'b0;

    issue(2'd0, 32'h00000021, 32'h00000022);
    expect_out("add_basic", 32'h00000043, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(2'd1, 32'h336FB7E5, 32'h336FB7E5);
    expect_out("sub_equal", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    issue(2'd0, 32'h7FFFFFFF, 32'h00000001);
    expect_out("add_ovf", 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);
    issue(2'd3, 32'hDEADBEEF, 32'h12345678);
    expect_out("clr", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    issue(2'd2, 32'd5, 32'hFFFFFFFF);
    chk("acc_5", acc, 32'd5);
    issue(2'd2, 32'd7, 32'd0);
    chk("acc_c", acc, 32'h0000000C);
    issue(2'd2, 32'hFFFFFFF4, 32'd0);
    expect_out("acc_wrap", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("acc_zero", acc, 32'd0);

    issue(2'd1, 32'h80000000, 32'h00000001);
    expect_out("sub_ovf", 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    issue(2'd0, 32'd1, 32'd1);
`ifdef ADDSUB_STICKY_V_EN
    expect_out("v_after_ovf", 32'd2, 1'b0, 1'b1, 1'b0, 1'b0);
`else
    expect_out("v_after_ovf", 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
    issue(2'd3, 32'd0, 32'd0);
    expect_out("clr_v", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Backpressure: one result held while a new transaction waits.
    repeat (3) @(posedge clk);
    #1;
    ready_mode = 2;
    @(posedge clk); #1;
    issue(2'd0, 32'd10, 32'd20);
    in_valid = 1'b1; in_op = 2'd1; in_a = 32'd100; in_b = 32'd1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      chk("hold_in_ready", in_ready, 1'b0);
      chk("hold_out", {out_valid, out_ans, acc}, {1'b1, exp_last.ans, exp_last.acc});
    end
    ready_mode = 0;
    issue(2'd1, 32'd100, 32'd1);
    for (int i = 0; i < 4; i++) issue(2'd2, 32'd3 + i, 32'd0);

    // Randomized traffic with random consumer stalls.
    picks[0] = 32'h0; picks[1] = 32'h7FFFFFFF; picks[2] = 32'h80000000; picks[3] = 32'hFFFFFFFF;
    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra, rb;
      picks[4] = $urandom;
      ra = picks[$urandom_range(0, 4)];
      picks[4] = $urandom;
      rb = picks[$urandom_range(0, 4)];
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end else begin
        issue(2'($urandom_range(0, 3)), ra, rb);
      end
    end
    ready_mode = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    // Asynchronous reset while a nonzero accumulator result is held.
    issue(2'd3, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    ready_mode = 2;
    @(posedge clk); #1;
    issue(2'd2, 32'h00001234, 32'd0);
    chk("pre_rst_held", {out_valid, acc}, {1'b1, 32'h00001234});
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {out_valid, acc, out_z, in_ready}, {1'b1 ^ 1'b1, 32'd0, 1'b1, 1'b1});
    sb_q.delete();
    acc_m = '0;
    sticky_m = 1'b0;
    ready_mode = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(2'd0, 32'd3, 32'd4);
    expect_out("post_rst_add", 32'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_final_empty", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
